mul_pipeline_unit: RTL

//   Parametrised, fully pipelined integer multiply execution unit; successor to the single-op mul unit.

---
 rtl/mul_pipeline_unit_pkg.sv | 16 +
 rtl/mul_pipeline_unit_stage.sv | 39 +++
 rtl/mul_pipeline_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mul_pipeline_unit_pkg.sv
// Shared types and constants for the pipelined multiply execution unit.
package mul_pipeline_unit_pkg;

  // Per-op decode bits issued alongside the operands.
  typedef struct packed {
    logic is_signed;
    logic high;
    logic oe;
    logic rc;
  } mul_pipe_ctrl_t;

  // Bit positions inside the XER word.
  localparam int XER_SO_BIT = 0;
  localparam int XER_OV_BIT = 1;

endpackage

// File: rtl/mul_pipeline_unit_stage.sv
// One pipeline slot: a valid bit plus an opaque payload.
// The valid bit is cleared by rst or flush; the payload is loaded whenever
// the slot advances and is never reset (downstream gates it with valid).
module mul_pipe_stage #(
  parameter type payload_t = logic
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     i_adv,
  input  logic     i_vld,
  input  payload_t i_pl,
  output logic     o_vld,
  output payload_t o_pl
);

  logic     r_vld;
  payload_t r_pl;

  // Valid bit: killed by reset/flush, otherwise takes upstream valid on advance.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_vld <= 1'b0;
    end else if (i_adv) begin
      r_vld <= i_vld;
    end
  end

  // Payload: captured on advance, held while stalled.
  always_ff @(posedge clk) begin
    if (i_adv) begin
      r_pl <= i_pl;
    end
  end

  assign o_vld = r_vld;
  assign o_pl  = r_pl;

endmodule

// File: rtl/mul_pipeline_unit.sv
// Fully pipelined integer multiply unit (mullw/mulli, mulhw, mulhwu).
// The 2W-bit product is formed at the pipe entrance and carried through
// STAGES slots; result word, overflow and CR0 are derived from the product
// held in the last slot. Backpressure collapses bubbles.
module mul_pipeline_unit
  import mul_pipeline_unit_pkg::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int OP_WIDTH    = 32,
  parameter int STAGES      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [RS_ID_WIDTH-1:0] rs_id_in,
  input  logic [4:0]             result_reg_addr_in,
  input  logic [OP_WIDTH-1:0]    op1,
  input  logic [OP_WIDTH-1:0]    op2,
  input  logic [OP_WIDTH-1:0]    xer_in,
  input  mul_pipe_ctrl_t         control,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [RS_ID_WIDTH-1:0] rs_id_out,
  output logic [4:0]             result_reg_addr_out,
  output logic [OP_WIDTH-1:0]    result,
  output logic [3:0]             cr0,
  output logic                   cr0_valid,
  output logic                   xer_so,
  output logic                   xer_ov,
  output logic                   xer_valid
);

  localparam int W = OP_WIDTH;

  // is_signed is consumed at the entrance, so it is not carried.
  typedef struct packed {
    logic [RS_ID_WIDTH-1:0] rs_id;
    logic [4:0]             addr;
    logic                   high;
    logic                   oe;
    logic                   rc;
    logic                   so_in;
    logic [2*W-1:0]         prod;
  } payload_t;

  // Overflow of a low-word multiply: the top W+1 product bits must all match.
  function automatic logic calc_ov(input logic [2*W-1:0] p, input logic high);
    logic [W:0] top;
    top = p[2*W-1:W-1];
    return ~high & ~((&top) | ~(|top));
  endfunction

  // CR0 = {LT, GT, EQ, SO} from a signed compare of the result against zero.
  function automatic logic [3:0] calc_cr0(input logic [W-1:0] r, input logic so);
    return {r[W-1], ~r[W-1] & (|r), ~(|r), so};
  endfunction

  // ---- stage-0 input: operand extension and full product ----
  // Extending straight to 2W bits gives the same low 2W product bits as a
  // (W+1)x(W+1) multiply, so no product bits are discarded.
  logic signed [2*W-1:0] w_op1_ext;
  logic signed [2*W-1:0] w_op2_ext;
  logic signed [2*W-1:0] w_prod_p0;
  payload_t              w_pl_p0;
  logic                  w_xer_unused;

  assign w_op1_ext = {{W{control.is_signed & op1[W-1]}}, op1};
  assign w_op2_ext = {{W{control.is_signed & op2[W-1]}}, op2};
  assign w_prod_p0 = w_op1_ext * w_op2_ext;
  assign w_xer_unused = ^xer_in[W-1:XER_SO_BIT+1];

  assign w_pl_p0.rs_id = rs_id_in;
  assign w_pl_p0.addr  = result_reg_addr_in;
  assign w_pl_p0.high  = control.high;
  assign w_pl_p0.oe    = control.oe;
  assign w_pl_p0.rc    = control.rc;
  assign w_pl_p0.so_in = xer_in[XER_SO_BIT];
  assign w_pl_p0.prod  = w_prod_p0;

  // ---- register stages ----
  logic     r_vld [STAGES];
  payload_t r_pl  [STAGES];
  logic     [STAGES:0] w_adv;

  // Advance chain: a slot moves if it is empty or the slot after it moves.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = output_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_adv[i] = ~r_vld[i] | w_adv[i+1];
    end
  end

  assign input_ready = w_adv[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic     w_vld_in;
    payload_t w_pl_in;
    if (g == 0) begin : g_first
      assign w_vld_in = input_valid;
      assign w_pl_in  = w_pl_p0;
    end else begin : g_next
      assign w_vld_in = r_vld[g-1];
      assign w_pl_in  = r_pl[g-1];
    end
    mul_pipe_stage #(
      .payload_t(payload_t)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .i_adv (w_adv[g]),
      .i_vld (w_vld_in),
      .i_pl  (w_pl_in),
      .o_vld (r_vld[g]),
      .o_pl  (r_pl[g])
    );
  end

  // ---- last stage: result select and flag derivation ----
  payload_t       w_last;
  logic [W-1:0]   w_res;
  logic           w_ov;
  logic           w_so;
  logic           w_xv;
  logic [3:0]     w_cr0;

  assign w_last = r_pl[STAGES-1];
  assign w_res  = w_last.high ? w_last.prod[2*W-1:W] : w_last.prod[W-1:0];
  assign w_ov   = calc_ov(w_last.prod, w_last.high);
  assign w_xv   = w_last.oe & ~w_last.high;
  assign w_so   = w_last.so_in | w_ov;
  assign w_cr0  = calc_cr0(w_res, w_xv ? w_so : w_last.so_in);

  // Outputs read zero whenever the last slot is empty (including after reset).
  always_comb begin
    output_valid        = r_vld[STAGES-1];
    rs_id_out           = '0;
    result_reg_addr_out = '0;
    result              = '0;
    cr0                 = '0;
    cr0_valid           = 1'b0;
    xer_so              = 1'b0;
    xer_ov              = 1'b0;
    xer_valid           = 1'b0;
    if (r_vld[STAGES-1]) begin
      rs_id_out           = w_last.rs_id;
      result_reg_addr_out = w_last.addr;
      result              = w_res;
      cr0                 = w_cr0;
      cr0_valid           = w_last.rc;
      xer_so              = w_so;
      xer_ov              = w_ov;
      xer_valid           = w_xv;
    end
  end

endmodule
